// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the elastic pipeline stage buffer.
// Holds the stage FSM encoding and the NOP word shown by an empty stage.
package pipe_stage_buf_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One payload register of the stage (main or skid).
// Clear has priority over load so a flush always wins against a same-cycle capture.
module pipe_stage_buf_slot #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register with a 2-entry skid buffer, valid/ready handshake,
// synchronous flush and a saturating back-pressure stall counter.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int W = INSTR_W + PC_W + DATA_W;

   state_t         state, state_nxt;
   logic           in_fire, out_fire;
   logic           main_load, main_clr, skid_load, skid_clr;
   logic [W-1:0]   in_word, main_d, main_q, skid_q;

   assign in_word   = {in_instr, in_pc, in_data};
   assign out_valid = (state != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   // When draining FULL the main slot refills from the skid slot, otherwise from the input.
   assign main_d    = (state == ST_FULL) ? skid_q : in_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != ST_FULL);
      end
   end

   always_comb begin
      state_nxt = state;
      main_load = 1'b0;
      main_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
         main_clr  = 1'b1;
         skid_clr  = 1'b1;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_nxt = ST_FULL;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
                  main_clr  = 1'b1;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_nxt = ST_ONE;
                  main_load = 1'b1;
                  skid_clr  = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
               main_clr  = 1'b1;
               skid_clr  = 1'b1;
            end
         endcase
      end
   end

   pipe_stage_buf_slot #(.W(W)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .clr   (main_clr),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_stage_buf_slot #(.W(W)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (skid_load),
      .clr   (skid_clr),
      .d     (in_word),
      .q     (skid_q)
   );

   assign out_instr = out_valid ? main_q[W-1 -: INSTR_W] : NOP_INSTR;
   assign out_pc    = out_valid ? main_q[DATA_W +: PC_W] : '0;
   assign out_data  = out_valid ? main_q[DATA_W-1:0]     : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and scoreboard bench for pipe_stage_buf (16-bit and 4-bit counter builds).
module tb_pipe_stage_buf;

   localparam int DATA_W = 64;
   localparam int PC_W   = 32;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, out_ready;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc;
   logic [DATA_W-1:0] in_data;

   logic              in_ready, out_valid;
   logic [31:0]       out_instr;
   logic [PC_W-1:0]   out_pc;
   logic [DATA_W-1:0] out_data;
   logic [15:0]       stall_cnt;

   logic              in_ready4, out_valid4;
   logic [31:0]       out_instr4;
   logic [PC_W-1:0]   out_pc4;
   logic [DATA_W-1:0] out_data4;
   logic [3:0]        stall_cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_buf #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4),
      .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_instr(out_instr4), .out_pc(out_pc4), .out_data(out_data4),
      .stall_cnt(stall_cnt4)
   );

   function automatic logic [DATA_W-1:0] data_of(input logic [PC_W-1:0] pc);
      return {pc ^ 32'hA5A5_0000, ~pc};
   endfunction

   function automatic logic [31:0] instr_of(input logic [PC_W-1:0] pc);
      return 32'h2000_0000 | pc;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PC_W-1:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_instr = instr_of(pc);
      in_data  = data_of(pc);
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0);
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'h1111);
      step(); step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      checks++;
      if (out_instr !== 32'h0 || out_pc !== '0 || out_data !== '0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: instr=%h pc=%h data=%h stall=%0d, want zeros",
                  out_instr, out_pc, out_data, stall_cnt);
      end
      reset = 1'b0;
      drive(1'b0, '0);
      step();
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      drive(1'b1, 32'h3000);
      in_instr = 32'h3C01_1234;
      step();
      drive(1'b0, '0);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h3C01_1234 || out_pc !== 32'h3000
          || out_data !== data_of(32'h3000)) begin
         errors++;
         $display("FAIL single_out: v=%b instr=%h pc=%h, want 1 3c011234 3000",
                  out_valid, out_instr, out_pc);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL single_empty: v=%b instr=%h pc=%h, want 0 0 0", out_valid, out_instr, out_pc);
      end
   endtask

   task automatic test_skid();
      out_ready = 1'b0;
      drive(1'b1, 32'h3000);
      step();
      checks++;
      if (in_ready !== 1'b1 || out_pc !== 32'h3000) begin
         errors++;
         $display("FAIL skid_one: in_ready=%b pc=%h, want 1 3000", in_ready, out_pc);
      end
      drive(1'b1, 32'h3004);
      step();
      drive(1'b0, '0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h3000) begin
         errors++;
         $display("FAIL skid_full: in_ready=%b v=%b pc=%h, want 0 1 3000", in_ready, out_valid, out_pc);
      end
      step();
      checks++;
      if (out_pc !== 32'h3000 || out_data !== data_of(32'h3000)) begin
         errors++;
         $display("FAIL skid_hold: pc=%h, want 3000", out_pc);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3004 || out_instr !== instr_of(32'h3004)
          || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL skid_drainB: v=%b pc=%h in_ready=%b, want 1 3004 1", out_valid, out_pc, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== '0) begin
         errors++;
         $display("FAIL skid_empty: v=%b pc=%h, want 0 0", out_valid, out_pc);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'h3100); step();
      drive(1'b1, 32'h3104); step();
      flush = 1'b1;
      drive(1'b1, 32'h4000);
      step();
      flush = 1'b0;
      drive(1'b0, '0);
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_full: v=%b instr=%h in_ready=%b, want 0 0 1", out_valid, out_instr, in_ready);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== '0) begin
         errors++;
         $display("FAIL flush_nodrop: v=%b pc=%h, want 0 0", out_valid, out_pc);
      end
      // flush in ONE with an accepted incoming entry: that entry is discarded
      out_ready = 1'b0;
      drive(1'b1, 32'h3200); step();
      flush = 1'b1;
      drive(1'b1, 32'h4004);
      step();
      flush = 1'b0;
      drive(1'b0, '0);
      step();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_one: v=%b pc=%h in_ready=%b, want 0 0 1", out_valid, out_pc, in_ready);
      end
   endtask

   task automatic test_stall_cnt();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'h5000);
      step();
      drive(1'b0, '0);
      repeat (10) step();
      checks++;
      if (stall_cnt !== 16'd10 || stall_cnt4 !== 4'd10) begin
         errors++;
         $display("FAIL stall_10: cnt16=%0d cnt4=%0d, want 10 10", stall_cnt, stall_cnt4);
      end
      checks++;
      if (out_valid4 !== 1'b1 || out_pc4 !== 32'h5000 || out_instr4 !== instr_of(32'h5000)
          || out_data4 !== data_of(32'h5000)) begin
         errors++;
         $display("FAIL stall_hold4: v=%b pc=%h, want 1 5000", out_valid4, out_pc4);
      end
      repeat (10) step();
      checks++;
      if (stall_cnt !== 16'd20 || stall_cnt4 !== 4'd15) begin
         errors++;
         $display("FAIL stall_sat: cnt16=%0d cnt4=%0d, want 20 15", stall_cnt, stall_cnt4);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      checks++;
      if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd21) begin
         errors++;
         $display("FAIL stall_flush: cnt16=%0d cnt4=%0d, want 21 15", stall_cnt, stall_cnt4);
      end
      checks++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_pc4 !== '0 || out_instr4 !== 32'h0
          || out_data4 !== '0) begin
         errors++;
         $display("FAIL stall_flush4: v=%b in_ready=%b pc=%h, want 0 1 0", out_valid4, in_ready4, out_pc4);
      end
   endtask

   task automatic test_back_to_back();
      logic [PC_W-1:0] exp_pc;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h3000 + 32'(4 * i));
         step();
         exp_pc = 32'h3000 + 32'(4 * i);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== instr_of(exp_pc)
             || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d: v=%b pc=%h in_ready=%b, want 1 %h 1", i, out_valid, out_pc, in_ready, exp_pc);
         end
      end
      drive(1'b0, '0);
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: v=%b, want 0", out_valid);
      end
   endtask

   task automatic test_random();
      logic [PC_W-1:0] q[$];
      logic [PC_W-1:0] next_pc;
      logic [PC_W-1:0] exp_pc;
      int budget;
      do_reset();
      next_pc = 32'h6000;
      for (int cyc = 0; cyc < 300; cyc++) begin
         drive(1'($urandom_range(0, 1)), next_pc);
         out_ready = ($urandom_range(0, 2) != 0);
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL rand_occ_%0d: v=%b in_ready=%b, model size %0d", cyc, out_valid, in_ready, q.size());
         end
         if (out_valid && out_ready) begin
            exp_pc = (q.size() > 0) ? q.pop_front() : '1;
            checks++;
            if (out_pc !== exp_pc || out_data !== data_of(exp_pc) || out_instr !== instr_of(exp_pc)) begin
               errors++;
               $display("FAIL rand_order_%0d: pc=%h, want %h", cyc, out_pc, exp_pc);
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
         end
         step();
      end
      drive(1'b0, '0);
      out_ready = 1'b1;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
         if (out_valid) begin
            exp_pc = q.pop_front();
            checks++;
            if (out_pc !== exp_pc) begin
               errors++;
               $display("FAIL rand_drain: pc=%h, want %h", out_pc, exp_pc);
            end
         end
         step();
         budget++;
      end
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_final: left=%0d v=%b, want 0 0", q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_skid();
      test_flush();
      test_stall_cnt();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
